// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point FFT frame controller.
package fft16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_S0     = 3'd2,
        ST_S1     = 3'd3,
        ST_S2     = 3'd4,
        ST_S3     = 3'd5,
        ST_UNLOAD = 3'd6
    } fft16_state_t;

    localparam int N = 16;

    localparam logic [1:0] STG0     = 2'b00;
    localparam logic [1:0] STG1     = 2'b01;
    localparam logic [1:0] STG2     = 2'b10;
    localparam logic [1:0] STG3     = 2'b11;
    // Stage 11 is the only code the core can idle on without corrupting data.
    localparam logic [1:0] STG_IDLE = 2'b11;

endpackage

// File: rtl/fft16_frame_ctrl.sv
// Wraps the open-loop 16-point FFT core controls in a valid/ready frame pipeline:
// load 16 samples, sequence four stages, unload 16 bins with a last marker.
module fft16_frame_ctrl
    import fft16_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OUT_W = 38
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_real,
    input  logic signed [WIDTH-1:0] s_image,
    output logic signed [WIDTH-1:0] fft_in_real,
    output logic signed [WIDTH-1:0] fft_in_image,
    output logic                    fft_in_EN,
    output logic                    fft_start,
    output logic [1:0]              fft_Stage,
    output logic                    fft_out_EN,
    input  logic [1:0]              fft_Done,
    input  logic signed [OUT_W-1:0] fft_out_real,
    input  logic signed [OUT_W-1:0] fft_out_image,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_real,
    output logic signed [OUT_W-1:0] m_image,
    output logic                    m_last,
    output logic                    busy,
    output logic                    seq_err
);

    localparam logic [3:0] LAST_IDX  = 4'(N - 1);
    localparam logic [4:0] REQ_TOTAL = 5'(N);

    fft16_state_t            state_reg, state_next;
    logic                    run_reg;
    logic [3:0]              load_cnt_reg;
    logic [3:0]              unload_cnt_reg;
    logic [4:0]              req_cnt_reg;
    logic                    inflight_reg;
    logic                    m_valid_reg;
    logic                    m_last_reg;
    logic signed [OUT_W-1:0] m_real_reg;
    logic signed [OUT_W-1:0] m_image_reg;
    logic                    chk_valid_reg;
    logic [1:0]              chk_stage_reg;
    logic                    seq_err_reg;
    logic                    in_stage;
    logic                    out_hs;

    assign fft_in_real  = s_real;
    assign fft_in_image = s_image;
    assign s_ready      = (state_reg == ST_LOAD);
    assign fft_in_EN    = s_valid & s_ready;
    // run_reg keeps fft_start low while reset is held and for the release edge.
    assign fft_start    = (state_reg == ST_IDLE) & run_reg;
    assign in_stage     = (state_reg == ST_S0) | (state_reg == ST_S1) |
                          (state_reg == ST_S2) | (state_reg == ST_S3);
    assign busy         = in_stage | (state_reg == ST_UNLOAD);
    assign out_hs       = m_valid_reg & m_ready;
    // One request in flight at most; the count cap keeps the core's index aligned.
    assign fft_out_EN   = (state_reg == ST_UNLOAD) & ~inflight_reg &
                          (~m_valid_reg | m_ready) & (req_cnt_reg != REQ_TOTAL);

    assign m_valid = m_valid_reg;
    assign m_last  = m_last_reg;
    assign m_real  = m_real_reg;
    assign m_image = m_image_reg;
    assign seq_err = seq_err_reg;

    always_comb begin
        fft_Stage = STG_IDLE;
        case (state_reg)
            ST_S0:   fft_Stage = STG0;
            ST_S1:   fft_Stage = STG1;
            ST_S2:   fft_Stage = STG2;
            ST_S3:   fft_Stage = STG3;
            default: fft_Stage = STG_IDLE;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (run_reg) state_next = ST_LOAD;
            ST_LOAD:   if (fft_in_EN && load_cnt_reg == LAST_IDX) state_next = ST_S0;
            ST_S0:     state_next = ST_S1;
            ST_S1:     state_next = ST_S2;
            ST_S2:     state_next = ST_S3;
            ST_S3:     state_next = ST_UNLOAD;
            ST_UNLOAD: if (out_hs && m_last_reg) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            run_reg        <= 1'b0;
            load_cnt_reg   <= '0;
            unload_cnt_reg <= '0;
            req_cnt_reg    <= '0;
            inflight_reg   <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            m_real_reg     <= '0;
            m_image_reg    <= '0;
            chk_valid_reg  <= 1'b0;
            chk_stage_reg  <= STG_IDLE;
            seq_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= 1'b1;
            inflight_reg  <= fft_out_EN;
            chk_valid_reg <= in_stage;
            chk_stage_reg <= fft_Stage;

            if (state_reg == ST_IDLE) begin
                load_cnt_reg <= '0;
            end else if (fft_in_EN) begin
                load_cnt_reg <= load_cnt_reg + 4'd1;
            end

            if (state_reg == ST_IDLE) begin
                req_cnt_reg <= '0;
            end else if (fft_out_EN) begin
                req_cnt_reg <= req_cnt_reg + 5'd1;
            end

            // The core presents the requested bin one cycle after fft_out_EN.
            if (state_reg == ST_IDLE) begin
                unload_cnt_reg <= '0;
            end else if (inflight_reg) begin
                unload_cnt_reg <= unload_cnt_reg + 4'd1;
            end

            if (inflight_reg) begin
                m_real_reg  <= fft_out_real;
                m_image_reg <= fft_out_image;
                m_valid_reg <= 1'b1;
                m_last_reg  <= (unload_cnt_reg == LAST_IDX);
            end else if (out_hs) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end

            if (chk_valid_reg && fft_Done != chk_stage_reg) begin
                seq_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl with a behavioural model of the FFT core.
module tb_fft16_frame_ctrl;

    localparam int WIDTH = 4;
    localparam int OUT_W = 38;

    logic                    clk;
    logic                    rst_n;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_real, s_image;
    logic signed [WIDTH-1:0] fft_in_real, fft_in_image;
    logic                    fft_in_EN, fft_start, fft_out_EN;
    logic [1:0]              fft_Stage, fft_Done;
    logic signed [OUT_W-1:0] fft_out_real, fft_out_image;
    logic                    m_valid, m_ready, m_last, busy, seq_err;
    logic signed [OUT_W-1:0] m_real, m_image;

    int n_checks = 0;
    int n_fail   = 0;

    fft16_frame_ctrl #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_image(s_image),
        .fft_in_real(fft_in_real), .fft_in_image(fft_in_image), .fft_in_EN(fft_in_EN),
        .fft_start(fft_start), .fft_Stage(fft_Stage), .fft_out_EN(fft_out_EN),
        .fft_Done(fft_Done), .fft_out_real(fft_out_real), .fft_out_image(fft_out_image),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_image(m_image),
        .m_last(m_last), .busy(busy), .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint dft(input int xr[16], input int xi[16], input int k, input bit im);
        real acc = 0.0;
        real th;
        for (int n = 0; n < 16; n++) begin
            th = 2.0 * 3.14159265358979 * real'(n * k) / 16.0;
            if (!im) acc = acc + real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
            else     acc = acc + real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
        end
        return longint'($floor(acc + 0.5));
    endfunction

    // Core model: load counter cleared by fft_start, Done tracks the executed stage,
    // free-running 4-bit output index advanced by fft_out_EN.
    int         cap_re [16];
    int         cap_im [16];
    logic [3:0] ld_idx, out_idx;
    logic       inject_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_idx        <= '0;
            out_idx       <= '0;
            fft_Done      <= 2'b11;
            fft_out_real  <= '0;
            fft_out_image <= '0;
        end else begin
            if (fft_start) begin
                ld_idx <= '0;
            end else if (fft_in_EN) begin
                cap_re[ld_idx] <= int'(fft_in_real);
                cap_im[ld_idx] <= int'(fft_in_image);
                ld_idx <= ld_idx + 4'd1;
            end
            if (!fft_in_EN) fft_Done <= (inject_bad && fft_Stage == 2'b10) ? 2'b00 : fft_Stage;
            if (fft_out_EN) begin
                fft_out_real  <= OUT_W'(dft(cap_re, cap_im, int'(out_idx), 1'b0));
                fft_out_image <= OUT_W'(dft(cap_re, cap_im, int'(out_idx), 1'b1));
                out_idx <= out_idx + 4'd1;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input int xr[16], input int xi[16], input int n, input bit gaps);
        int  i = 0;
        int  cyc = 0;
        int  pulses = 0;
        int  gap_bad = 0;
        bit  acc;
        while (i < n && cyc < 300) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_real  = WIDTH'(xr[i]);
            s_image = WIDTH'(xi[i]);
            @(negedge clk);
            cyc++;
            acc = s_valid && s_ready;
            if (fft_in_EN) pulses++;
            if (s_ready && !fft_in_EN && fft_Stage !== 2'b11) gap_bad++;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        s_valid = 1'b0;
        check("samples_accepted", i, n);
        check("in_en_pulses", pulses, n);
        check("gap_stage_idle", gap_bad, 0);
    endtask

    task automatic recv_frame(input longint er[16], input longint ei[16], input int stall_bin,
                              output int first_valid);
        int     cnt = 0;
        int     cyc = 0;
        int     stall_left = 0;
        bit     stalled = 0;
        bit     have_hold = 0;
        longint hr = 0;
        longint hi = 0;
        int     oen_during = 0;
        int     unstable = 0;
        first_valid = -1;
        m_ready = 1'b1;
        while (cnt < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc <= 4) check($sformatf("stage_s%0d", cyc - 1), longint'(fft_Stage), cyc - 1);
            if (cyc == 1) check("s_ready_in_s0", s_ready, 0);
            if (cyc == 5) check("first_out_en", fft_out_EN, 1);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (stall_left > 0) begin
                if (fft_out_EN) oen_during++;
                if (m_valid) begin
                    if (!have_hold) begin
                        hr = m_real;
                        hi = m_image;
                        have_hold = 1;
                    end else if (m_real != hr || m_image != hi) begin
                        unstable++;
                    end
                end
                stall_left--;
                if (stall_left == 0) begin
                    check("stall_out_en", oen_during, 0);
                    check("stall_hold", unstable, 0);
                    check("stall_valid", m_valid, 1);
                end
            end else if (m_valid && m_ready) begin
                check($sformatf("bin%0d_re", cnt), m_real, er[cnt]);
                check($sformatf("bin%0d_im", cnt), m_image, ei[cnt]);
                check($sformatf("bin%0d_last", cnt), m_last, (cnt == 15) ? 1 : 0);
                cnt++;
            end
            @(posedge clk);
            #1;
            if (stall_bin >= 0 && cnt == stall_bin && !stalled) begin
                stalled = 1;
                stall_left = 10;
                m_ready = 1'b0;
            end else if (stall_left == 0) begin
                m_ready = 1'b1;
            end
        end
        check("bins_received", cnt, 16);
    endtask

    // IDLE cycle with fft_start, then LOAD with s_ready.
    task automatic after_frame(input bit exp_err);
        @(negedge clk);
        check("idle_s_ready", s_ready, 0);
        check("idle_fft_start", fft_start, 1);
        check("idle_busy", busy, 0);
        check("seq_err", seq_err, exp_err);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("load_s_ready", s_ready, 1);
        check("load_fft_start", fft_start, 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int  a_re, a_im;    // sample 0
        int  c_re, c_im;    // samples 1..15
        bit  gaps;
        bit  inject;
        int  e0_re, e0_im;  // bin 0
        int  ek_re, ek_im;  // bins 1..15
        bit  exp_err;
    } vec_t;

    vec_t   vecs [4];
    int     xr [16];
    int     xi [16];
    longint er [16];
    longint ei [16];
    int     fv;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // X[0] = a + 15c, X[k>0] = a - c for sample 0 = a and all others = c.
        vecs[0] = '{a_re: 1,  a_im: 0,  c_re: 0,  c_im: 0,  gaps: 0, inject: 0,
                    e0_re: 1,   e0_im: 0,   ek_re: 1,   ek_im: 0,   exp_err: 0};
        vecs[1] = '{a_re: 7,  a_im: -8, c_re: -1, c_im: 2,  gaps: 1, inject: 0,
                    e0_re: -8,  e0_im: 22,  ek_re: 8,   ek_im: -10, exp_err: 0};
        vecs[2] = '{a_re: -8, a_im: -8, c_re: 7,  c_im: 7,  gaps: 1, inject: 1,
                    e0_re: 97,  e0_im: 97,  ek_re: -15, ek_im: -15, exp_err: 1};
        vecs[3] = '{a_re: 1,  a_im: 1,  c_re: 1,  c_im: 1,  gaps: 0, inject: 0,
                    e0_re: 16,  e0_im: 16,  ek_re: 0,   ek_im: 0,   exp_err: 1};

        rst_n = 1'b0;
        s_valid = 1'b1;
        s_real = '0;
        s_image = '0;
        m_ready = 1'b1;
        inject_bad = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_fft_in_en", fft_in_EN, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_fft_stage", longint'(fft_Stage), 3);
        check("rst_fft_out_en", fft_out_EN, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_real", m_real, 0);
        check("rst_m_image", m_image, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_err", seq_err, 0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        after_frame(1'b0);

        for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < 16; n++) begin
                xr[n] = (n == 0) ? vecs[v].a_re : vecs[v].c_re;
                xi[n] = (n == 0) ? vecs[v].a_im : vecs[v].c_im;
                er[n] = (n == 0) ? vecs[v].e0_re : vecs[v].ek_re;
                ei[n] = (n == 0) ? vecs[v].e0_im : vecs[v].ek_im;
            end
            inject_bad = vecs[v].inject;
            send_frame(xr, xi, 16, vecs[v].gaps);
            recv_frame(er, ei, -1, fv);
            inject_bad = 1'b0;
            check("first_valid_latency", fv, 7);
            $display("frame %0d: sample0=(%0d,%0d) fill=(%0d,%0d) gaps=%0d inject=%0d done",
                     v, vecs[v].a_re, vecs[v].a_im, vecs[v].c_re, vecs[v].c_im,
                     vecs[v].gaps, vecs[v].inject);
            after_frame(vecs[v].exp_err);
        end

        // Reset in the middle of a load, then a clean all-(1,1) frame.
        for (int n = 0; n < 16; n++) begin
            xr[n] = 1;
            xi[n] = 1;
            er[n] = (n == 0) ? 16 : 0;
            ei[n] = (n == 0) ? 16 : 0;
        end
        send_frame(xr, xi, 7, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_s_ready", s_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fft_start", fft_start, 0);
        check("midrst_fft_stage", longint'(fft_Stage), 3);
        check("midrst_seq_err", seq_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        after_frame(1'b0);
        send_frame(xr, xi, 16, 1'b0);
        recv_frame(er, ei, -1, fv);
        check("first_valid_latency", fv, 7);
        $display("frame after mid-load reset: all (1,1) done");
        after_frame(1'b0);

        // Ramp frame with distinct bins, 10-cycle stall at bin 5.
        for (int n = 0; n < 16; n++) begin
            xr[n] = n - 8;
            xi[n] = 0;
        end
        for (int k = 0; k < 16; k++) begin
            er[k] = dft(xr, xi, k, 1'b0);
            ei[k] = dft(xr, xi, k, 1'b1);
        end
        send_frame(xr, xi, 16, 1'b0);
        recv_frame(er, ei, 5, fv);
        check("first_valid_latency", fv, 7);
        $display("frame ramp with output stall at bin 5 done");
        after_frame(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
